// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - OV7670-style camera frame-capture sequencer writing RGB565 words to frame RAM
//
// Purpose:
//   Synchronises the camera pins into the system clock domain, finds frame
//   (vsync) and line (href) boundaries, packs byte pairs into RGB565 words and
//   drives the RAM write port. Supports single-shot and continuous capture and
//   flags frame-geometry errors.
//
// Build option:
//   CAPTURE_DECIMATE_EN - when defined, 2x2 subsampling: only even pixels of
//   even lines are written and the address limit is (H_ACTIVE/2)*(V_ACTIVE/2).
//
// Ports:
//   clk         system clock (>= 4x pixel clock)
//   rst         asynchronous reset, active-high
//   start       one-cycle pulse, arms capture (ignored outside IDLE)
//   continuous  re-arm after each frame, sampled when DONE is left
//   cam_vsync   camera vsync (async), high during vertical blanking
//   cam_href    camera href (async), high during active bytes
//   cam_pclk    camera pixel clock, sampled as data
//   cam_data    camera byte bus
//   mem_we      RAM write strobe, one clk per pixel
//   mem_adr     RAM word address
//   mem_dat     RGB565 pixel {first byte, second byte}
//   busy        high while waiting for a frame or capturing
//   frame_done  one-cycle pulse at end of a captured frame
//   frame_err   sticky geometry-error flag, cleared by start or rst
//   line_cnt    lines completed in the current frame

module cam_capture_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_pclk,
  input  logic [7:0]        cam_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [15:0]       mem_dat,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [9:0]        line_cnt
);

`ifdef CAPTURE_DECIMATE_EN
  localparam int LIMIT = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
  localparam int LIMIT = H_ACTIVE * V_ACTIVE;
`endif
  localparam int LINE_BYTES = 2 * H_ACTIVE;
  localparam int BC_W = $clog2(LINE_BYTES + 2) + 1;
  localparam logic [ADDR_W:0] LIMIT_V      = (ADDR_W + 1)'(LIMIT);
  localparam logic [BC_W-1:0] LINE_BYTES_V = BC_W'(LINE_BYTES);
  localparam logic [BC_W-1:0] BC_MAX       = '1;
  localparam logic [9:0]      V_ACTIVE_V   = 10'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DONE} state_t;

  state_t state, next_state;

  // bit0/bit1 form the 2-FF synchronizer, bit2 is the edge-detect history
  logic [2:0] vs_sr, hr_sr, pc_sr;
  logic [7:0] data_s1, data_s2;

  logic            phase;
  logic [7:0]      hi_byte;
  logic [BC_W-1:0] byte_cnt;

  logic            pclk_rise, vs_rise, vs_fall, href_fall, href_lvl;
  logic            in_active, byte_ev, keep_pix, at_limit;
  logic [9:0]      line_inc, line_next;
  logic [ADDR_W:0] adr_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_sr   <= '0;
      hr_sr   <= '0;
      pc_sr   <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      vs_sr   <= {vs_sr[1:0], cam_vsync};
      hr_sr   <= {hr_sr[1:0], cam_href};
      pc_sr   <= {pc_sr[1:0], cam_pclk};
      data_s1 <= cam_data;
      data_s2 <= data_s1;
    end
  end

  assign pclk_rise = pc_sr[1] & ~pc_sr[2];
  assign vs_rise   = vs_sr[1] & ~vs_sr[2];
  assign vs_fall   = ~vs_sr[1] & vs_sr[2];
  assign href_fall = ~hr_sr[1] & hr_sr[2];
  assign href_lvl  = hr_sr[1];

  assign in_active = (state == ACTIVE);
  // A pclk edge coinciding with the href fall is not a byte of the line
  assign byte_ev   = in_active & pclk_rise & href_lvl & ~href_fall;

  assign line_inc  = (line_cnt == 10'h3FF) ? line_cnt : line_cnt + 10'd1;
  // Frame check at vsync rise must see a line ending in the same cycle
  assign line_next = (in_active && href_fall) ? line_inc : line_cnt;

  // mem_adr lags mem_we by one cycle, so count an in-flight write as done
  assign adr_eff  = {1'b0, mem_adr} + {{ADDR_W{1'b0}}, mem_we};
  assign at_limit = (adr_eff >= LIMIT_V);

`ifdef CAPTURE_DECIMATE_EN
  // byte_cnt is the index of the second byte of the pixel (2p+1); bit1 clear means p is even
  assign keep_pix = ~line_cnt[0] & ~byte_cnt[1];
`else
  assign keep_pix = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = WAIT_VS;
      end
      WAIT_VS: begin
        busy = 1'b1;
        if (vs_fall) next_state = ACTIVE;
      end
      ACTIVE: begin
        busy = 1'b1;
        if (vs_rise) next_state = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = continuous ? WAIT_VS : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_dat   <= '0;
      frame_err <= 1'b0;
      line_cnt  <= '0;
      phase     <= 1'b0;
      hi_byte   <= '0;
      byte_cnt  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (mem_we) mem_adr <= mem_adr + 1'b1;

      if (state == IDLE && start) frame_err <= 1'b0;

      if (state == WAIT_VS && vs_fall) begin
        mem_adr  <= '0;
        line_cnt <= '0;
        phase    <= 1'b0;
        byte_cnt <= '0;
      end

      if (byte_ev) begin
        if (byte_cnt != BC_MAX) byte_cnt <= byte_cnt + 1'b1;
        if (!phase) begin
          hi_byte <= data_s2;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (keep_pix) begin
            if (at_limit) begin
              frame_err <= 1'b1;
            end else begin
              mem_dat <= {hi_byte, data_s2};
              mem_we  <= 1'b1;
            end
          end
        end
      end

      if (in_active && href_fall) begin
        line_cnt <= line_next;
        // an odd trailing byte is dropped by simply clearing the phase
        if (byte_cnt != LINE_BYTES_V || phase) frame_err <= 1'b1;
        phase    <= 1'b0;
        byte_cnt <= '0;
      end

      if (in_active && vs_rise && line_next != V_ACTIVE_V) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - directed self-checking bench for cam_capture_ctrl
module tb_cam_capture_ctrl;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          continuous;
  logic          cam_vsync;
  logic          cam_href;
  logic          cam_pclk;
  logic [7:0]    cam_data;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [15:0]   mem_dat;
  logic          busy;
  logic          frame_done;
  logic          frame_err;
  logic [9:0]    line_cnt;

  int checks = 0;
  int passes = 0;

  int          nw = 0;
  int          nd = 0;
  logic [AW-1:0] wr_adr [0:63];
  logic [15:0]   wr_dat [0:63];

  cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pclk(cam_pclk),
    .cam_data(cam_data), .mem_we(mem_we), .mem_adr(mem_adr), .mem_dat(mem_dat),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we && nw < 64) begin
      wr_adr[nw] = mem_adr;
      wr_dat[nw] = mem_dat;
      nw = nw + 1;
    end
    if (frame_done) nd = nd + 1;
  end

  function automatic logic [15:0] pr(input int b);
    logic [7:0] a, c;
    a = 8'(b);
    c = 8'(b + 1);
    return {a, c};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input int b);
    cam_data = 8'(b);
    wait_clk(3);
    cam_pclk = 1'b1;
    wait_clk(3);
    cam_pclk = 1'b0;
  endtask

  task automatic send_line(input int n, input int base);
    cam_href = 1'b1;
    for (int k = 0; k < n; k++) send_byte(base + k);
    wait_clk(2);
    cam_href = 1'b0;
    wait_clk(6);
  endtask

  // vsync assumed high on entry; line l carries bytes 8*l+1 ..
  task automatic run_frame(input int nlines);
    wait_clk(4);
    cam_vsync = 1'b0;
    wait_clk(6);
    for (int l = 0; l < nlines; l++) send_line(2 * H, 8 * l + 1);
    cam_vsync = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(3);
    checks++; if ({mem_we, mem_adr, mem_dat} !== '0) $display("FAIL reset_mem: got we=%b adr=%0d dat=%h want 0", mem_we, mem_adr, mem_dat); else passes++;
    checks++; if ({busy, frame_done, frame_err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, frame_done, frame_err}); else passes++;
    checks++; if (line_cnt !== 10'd0) $display("FAIL reset_line_cnt: got %0d want 0", line_cnt); else passes++;
    rst = 1'b0;
    wait_clk(2);
  endtask

  task automatic test_single_frame();
    int base, b;
    base = nw; b = nd;
    pulse_start();
    checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passes++;
    run_frame(2);
    checks++; if (nw - base !== 8) $display("FAIL single_nwrites: got %0d want 8", nw - base); else passes++;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (wr_adr[base + j] !== AW'(j) || wr_dat[base + j] !== pr(2 * j + 1))
        $display("FAIL single_write%0d: got adr=%0d dat=%h want adr=%0d dat=%h", j, wr_adr[base + j], wr_dat[base + j], j, pr(2 * j + 1));
      else passes++;
    end
    checks++; if (nd - b !== 1) $display("FAIL single_done: got %0d pulses want 1", nd - b); else passes++;
    checks++; if (frame_err !== 1'b0) $display("FAIL single_err: got %b want 0", frame_err); else passes++;
    checks++; if (line_cnt !== 10'd2) $display("FAIL single_line_cnt: got %0d want 2", line_cnt); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL single_idle: got busy=%b want 0", busy); else passes++;
  endtask

  task automatic test_odd_line();
    int base;
    logic [15:0] exp;
    base = nw;
    pulse_start();
    checks++; if (frame_err !== 1'b0) $display("FAIL odd_err_cleared: got %b want 0", frame_err); else passes++;
    wait_clk(4);
    cam_vsync = 1'b0;
    wait_clk(6);
    send_line(7, 1);
    checks++; if (nw - base !== 3) $display("FAIL odd_line_writes: got %0d want 3", nw - base); else passes++;
    checks++; if (frame_err !== 1'b1) $display("FAIL odd_err: got %b want 1", frame_err); else passes++;
    send_line(8, 9);
    cam_vsync = 1'b1;
    wait_clk(8);
    checks++; if (nw - base !== 7) $display("FAIL odd_total: got %0d want 7", nw - base); else passes++;
    for (int j = 0; j < 7; j++) begin
      exp = (j < 3) ? pr(2 * j + 1) : pr(9 + 2 * (j - 3));
      checks++;
      if (wr_adr[base + j] !== AW'(j) || wr_dat[base + j] !== exp)
        $display("FAIL odd_write%0d: got adr=%0d dat=%h want adr=%0d dat=%h", j, wr_adr[base + j], wr_dat[base + j], j, exp);
      else passes++;
    end
  endtask

  task automatic test_addr_limit();
    int base;
    base = nw;
    pulse_start();
    run_frame(3);
    checks++; if (nw - base !== 8) $display("FAIL limit_writes: got %0d want 8", nw - base); else passes++;
    checks++; if (wr_adr[base + 7] !== AW'(7)) $display("FAIL limit_last_adr: got %0d want 7", wr_adr[base + 7]); else passes++;
    checks++; if (mem_adr !== AW'(8)) $display("FAIL limit_adr_hold: got %0d want 8", mem_adr); else passes++;
    checks++; if (frame_err !== 1'b1) $display("FAIL limit_err: got %b want 1", frame_err); else passes++;
    checks++; if (line_cnt !== 10'd3) $display("FAIL limit_line_cnt: got %0d want 3", line_cnt); else passes++;
  endtask

  task automatic test_back_to_back();
    int base, b;
    base = nw; b = nd;
    continuous = 1'b1;
    pulse_start();
    run_frame(2);
    checks++; if (nd - b !== 1) $display("FAIL b2b_done1: got %0d want 1", nd - b); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL b2b_busy_gap: got %b want 1", busy); else passes++;
    continuous = 1'b0;
    run_frame(2);
    checks++; if (nd - b !== 2) $display("FAIL b2b_done2: got %0d want 2", nd - b); else passes++;
    checks++; if (nw - base !== 16) $display("FAIL b2b_writes: got %0d want 16", nw - base); else passes++;
    checks++; if (wr_adr[base + 8] !== AW'(0) || wr_adr[base + 15] !== AW'(7))
      $display("FAIL b2b_adr_restart: got %0d..%0d want 0..7", wr_adr[base + 8], wr_adr[base + 15]); else passes++;
    checks++; if (wr_dat[base + 8] !== 16'h0102) $display("FAIL b2b_dat: got %h want 0102", wr_dat[base + 8]); else passes++;
    checks++; if (frame_err !== 1'b0) $display("FAIL b2b_err: got %b want 0", frame_err); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_idle: got busy=%b want 0", busy); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int base, t;
    pulse_start();
    wait_clk(4);
    cam_vsync = 1'b0;
    wait_clk(6);
    cam_href = 1'b1;
    for (int k = 0; k < 3; k++) send_byte(k + 1);
    cam_data = 8'h04;
    wait_clk(3);
    cam_pclk = 1'b1;
    t = 0;
    while (mem_we !== 1'b1 && t < 20) begin
      wait_clk(1);
      t++;
    end
    checks++; if (t >= 20) $display("FAIL rstmid_we_timeout: got no write want mem_we=1"); else passes++;
    rst = 1'b1;
    #1;
    checks++; if ({mem_we, mem_adr, mem_dat} !== '0) $display("FAIL rstmid_mem: got we=%b adr=%0d dat=%h want 0", mem_we, mem_adr, mem_dat); else passes++;
    checks++; if ({busy, frame_err, line_cnt} !== '0) $display("FAIL rstmid_flags: got busy=%b err=%b lines=%0d want 0", busy, frame_err, line_cnt); else passes++;
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    base = nw;
    pulse_start();
    send_line(8, 1);
    checks++; if (nw - base !== 0) $display("FAIL rstmid_no_fall: got %0d writes want 0", nw - base); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL rstmid_wait: got busy=%b want 1", busy); else passes++;
    cam_vsync = 1'b1;
    run_frame(2);
    checks++; if (nw - base !== 8) $display("FAIL rstmid_frame: got %0d writes want 8", nw - base); else passes++;
    checks++; if (wr_adr[base] !== AW'(0) || wr_dat[base] !== 16'h0102)
      $display("FAIL rstmid_first: got adr=%0d dat=%h want adr=0 dat=0102", wr_adr[base], wr_dat[base]); else passes++;
  endtask

  task automatic test_decimate();
    int base;
    base = nw;
    pulse_start();
    run_frame(2);
    checks++; if (nw - base !== 2) $display("FAIL dec_writes: got %0d want 2", nw - base); else passes++;
    checks++; if (wr_adr[base] !== AW'(0) || wr_dat[base] !== 16'h0102)
      $display("FAIL dec_w0: got adr=%0d dat=%h want 0/0102", wr_adr[base], wr_dat[base]); else passes++;
    checks++; if (wr_adr[base + 1] !== AW'(1) || wr_dat[base + 1] !== 16'h0506)
      $display("FAIL dec_w1: got adr=%0d dat=%h want 1/0506", wr_adr[base + 1], wr_dat[base + 1]); else passes++;
    checks++; if (frame_err !== 1'b0) $display("FAIL dec_err: got %b want 0", frame_err); else passes++;
    checks++; if (line_cnt !== 10'd2) $display("FAIL dec_line_cnt: got %0d want 2", line_cnt); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    cam_vsync = 1'b1;
    cam_href = 1'b0;
    cam_pclk = 1'b0;
    cam_data = 8'h00;
    test_reset();
`ifdef CAPTURE_DECIMATE_EN
    test_decimate();
`else
    test_single_frame();
    test_odd_line();
    test_addr_limit();
    test_back_to_back();
    test_reset_mid_frame();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end

endmodule
